// File: rtl/gat_bram_loader.sv
// Load sequencer: takes one 32-bit valid/ready word stream and writes it into the
// H-data, node-info and weight BRAM ports in order, flagging each region when it is full.
module gat_bram_loader #(
  parameter int H_DATA_DEPTH     = 242101,
  parameter int NODE_INFO_DEPTH  = 13264,
  parameter int WEIGHT_DEPTH     = 22928,
  parameter int H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH),
  parameter int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
  parameter int WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  output logic                        load_busy,
  output logic                        load_err,
  output logic [31:0]                 words_loaded,
  input  logic                        s_valid,
  input  logic [31:0]                 s_data,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [31:0]                 h_data_bram_din,
  output logic                        h_data_bram_ena,
  output logic                        h_data_bram_wea,
  output logic [H_DATA_ADDR_W+1:0]    h_data_bram_addra,
  output logic [31:0]                 h_node_info_bram_din,
  output logic                        h_node_info_bram_ena,
  output logic                        h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W+1:0] h_node_info_bram_addra,
  output logic [31:0]                 wgt_bram_din,
  output logic                        wgt_bram_ena,
  output logic                        wgt_bram_wea,
  output logic [WEIGHT_ADDR_W+1:0]    wgt_bram_addra,
  output logic                        h_data_bram_load_done,
  output logic                        h_node_info_bram_load_done,
  output logic                        wgt_bram_load_done
);
  localparam int IDX_W0 = (H_DATA_ADDR_W > NODE_INFO_ADDR_W) ? H_DATA_ADDR_W : NODE_INFO_ADDR_W;
  localparam int IDX_W  = (IDX_W0 > WEIGHT_ADDR_W) ? IDX_W0 : WEIGHT_ADDR_W;

  typedef enum logic [2:0] {IDLE, LOAD_H, LOAD_NI, LOAD_W, DONE, ERR} state_t;

  state_t           state, next;
  logic [IDX_W-1:0] idx;
  logic             in_load, accept, start, region_end;
  logic [2:0]       fin_q;   // one-cycle marker: the strobe now on the bus closes a region

  assign in_load = (state == LOAD_H) || (state == LOAD_NI) || (state == LOAD_W);
  assign s_ready = in_load;
  assign accept  = s_valid & in_load;
  assign start   = load_start & ((state == IDLE) || (state == DONE) || (state == ERR));

  always_comb begin
    region_end = 1'b0;
    case (state)
      LOAD_H:  region_end = (idx == IDX_W'(H_DATA_DEPTH - 1));
      LOAD_NI: region_end = (idx == IDX_W'(NODE_INFO_DEPTH - 1));
      LOAD_W:  region_end = (idx == IDX_W'(WEIGHT_DEPTH - 1));
      default: region_end = 1'b0;
    endcase
  end

  always_comb begin
    next = state;
    if (start) next = LOAD_H;
    else if (accept) begin
      // s_last is legal only on the final weight word; its absence there is also an error
      if (s_last && !(state == LOAD_W && region_end)) next = ERR;
      else if (region_end) begin
        case (state)
          LOAD_H:  next = LOAD_NI;
          LOAD_NI: next = LOAD_W;
          default: next = s_last ? DONE : ERR;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx                        <= '0;
      fin_q                      <= '0;
      load_busy                  <= 1'b0;
      load_err                   <= 1'b0;
      words_loaded               <= '0;
      h_data_bram_din            <= '0;
      h_data_bram_ena            <= 1'b0;
      h_data_bram_wea            <= 1'b0;
      h_data_bram_addra          <= '0;
      h_node_info_bram_din       <= '0;
      h_node_info_bram_ena       <= 1'b0;
      h_node_info_bram_wea       <= 1'b0;
      h_node_info_bram_addra     <= '0;
      wgt_bram_din               <= '0;
      wgt_bram_ena               <= 1'b0;
      wgt_bram_wea               <= 1'b0;
      wgt_bram_addra             <= '0;
      h_data_bram_load_done      <= 1'b0;
      h_node_info_bram_load_done <= 1'b0;
      wgt_bram_load_done         <= 1'b0;
    end else begin
      load_busy            <= (next == LOAD_H) || (next == LOAD_NI) || (next == LOAD_W);
      fin_q                <= '0;
      h_data_bram_ena      <= 1'b0;
      h_data_bram_wea      <= 1'b0;
      h_node_info_bram_ena <= 1'b0;
      h_node_info_bram_wea <= 1'b0;
      wgt_bram_ena         <= 1'b0;
      wgt_bram_wea         <= 1'b0;
      h_data_bram_load_done      <= h_data_bram_load_done      | fin_q[0];
      h_node_info_bram_load_done <= h_node_info_bram_load_done | fin_q[1];
      wgt_bram_load_done         <= wgt_bram_load_done         | fin_q[2];
      if (start) begin
        idx                        <= '0;
        load_err                   <= 1'b0;
        words_loaded               <= '0;
        h_data_bram_load_done      <= 1'b0;
        h_node_info_bram_load_done <= 1'b0;
        wgt_bram_load_done         <= 1'b0;
      end else if (accept) begin
        idx          <= region_end ? '0 : idx + 1'b1;
        words_loaded <= words_loaded + 32'd1;
        if (next == ERR) load_err <= 1'b1;
        case (state)
          LOAD_H: begin
            h_data_bram_din   <= s_data;
            h_data_bram_ena   <= 1'b1;
            h_data_bram_wea   <= 1'b1;
            h_data_bram_addra <= {idx[H_DATA_ADDR_W-1:0], 2'b00};
            fin_q[0]          <= region_end;
          end
          LOAD_NI: begin
            h_node_info_bram_din   <= s_data;
            h_node_info_bram_ena   <= 1'b1;
            h_node_info_bram_wea   <= 1'b1;
            h_node_info_bram_addra <= {idx[NODE_INFO_ADDR_W-1:0], 2'b00};
            fin_q[1]               <= region_end;
          end
          default: begin
            wgt_bram_din   <= s_data;
            wgt_bram_ena   <= 1'b1;
            wgt_bram_wea   <= 1'b1;
            wgt_bram_addra <= {idx[WEIGHT_ADDR_W-1:0], 2'b00};
            fin_q[2]       <= region_end;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gat_bram_loader.sv
// Scoreboarded random bench for gat_bram_loader with small region depths (4/3/2).
module tb_gat_bram_loader;
  localparam int HD = 4, ND = 3, WD = 2, TOT = HD + ND + WD;
  localparam int HAW = $clog2(HD), NAW = $clog2(ND), WAW = $clog2(WD);

  logic clk = 1'b0, rst = 1'b1, load_start = 1'b0;
  logic load_busy, load_err, s_ready;
  logic [31:0] words_loaded;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic [31:0] h_din, n_din, w_din;
  logic h_ena, h_wea, n_ena, n_wea, w_ena, w_wea;
  logic [HAW+1:0] h_addr;
  logic [NAW+1:0] n_addr;
  logic [WAW+1:0] w_addr;
  logic h_done, n_done, w_done;

  gat_bram_loader #(.H_DATA_DEPTH(HD), .NODE_INFO_DEPTH(ND), .WEIGHT_DEPTH(WD)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_busy(load_busy),
    .load_err(load_err), .words_loaded(words_loaded),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .h_data_bram_din(h_din), .h_data_bram_ena(h_ena), .h_data_bram_wea(h_wea),
    .h_data_bram_addra(h_addr),
    .h_node_info_bram_din(n_din), .h_node_info_bram_ena(n_ena), .h_node_info_bram_wea(n_wea),
    .h_node_info_bram_addra(n_addr),
    .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addr),
    .h_data_bram_load_done(h_done), .h_node_info_bram_load_done(n_done),
    .wgt_bram_load_done(w_done));

  always #5 clk = ~clk;

  typedef struct {int region; int addr; logic [31:0] din; int cyc; bit last;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, k = 0;
  int dcyc[3] = '{-1, -1, -1};
  bit tog = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tog <= ~tog;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, in the right cycle.
  always @(negedge clk) begin
    int n, reg_a, addr_a;
    logic [31:0] din_a;
    logic wea_a;
    logic [2:0] dn;
    exp_t e;
    dn = {w_done, n_done, h_done};
    for (int r = 0; r < 3; r++)
      if (dcyc[r] == cyc) begin
        chk($sformatf("done_rise_r%0d", r), 64'(dn[r]), 64'd1);
        dcyc[r] = -1;
      end
    n = int'(h_ena) + int'(n_ena) + int'(w_ena);
    if (n > 0) begin
      reg_a  = h_ena ? 0 : (n_ena ? 1 : 2);
      addr_a = h_ena ? int'(h_addr) : (n_ena ? int'(n_addr) : int'(w_addr));
      din_a  = h_ena ? h_din : (n_ena ? n_din : w_din);
      wea_a  = h_ena ? h_wea : (n_ena ? n_wea : w_wea);
      total++;
      if (n > 1 || sb.size() == 0) begin
        bad++;
        $display("FAIL write_strobe: got %0d strobes with %0d pending expected (cycle %0d)",
                 n, sb.size(), cyc);
      end else begin
        e = sb.pop_front();
        if (reg_a != e.region || addr_a != e.addr || din_a !== e.din || cyc != e.cyc || wea_a !== 1'b1) begin
          bad++;
          $display("FAIL write: got r%0d a%0d d%0h c%0d wea%0b expected r%0d a%0d d%0h c%0d wea1",
                   reg_a, addr_a, din_a, cyc, wea_a, e.region, e.addr, e.din, e.cyc);
        end
        if (e.last) begin
          chk($sformatf("done_low_at_strobe_r%0d", e.region), 64'(dn[e.region]), 64'd0);
          dcyc[e.region] = cyc + 1;
        end
      end
    end
  end

  // Reference: the k-th accepted word of a sequence lands in region/offset by plain counting.
  function automatic exp_t model(input int kk, input logic [31:0] d, input int c);
    exp_t e;
    int base;
    e.region = (kk < HD) ? 0 : (kk < HD + ND) ? 1 : 2;
    base     = (e.region == 0) ? 0 : (e.region == 1) ? HD : HD + ND;
    e.addr   = (kk - base) * 4;
    e.din    = d;
    e.cyc    = c;
    e.last   = (kk == HD - 1) || (kk == HD + ND - 1) || (kk == TOT - 1);
    return e;
  endfunction

  task automatic do_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    k = 0;
    dcyc = '{-1, -1, -1};
    @(negedge clk);
    chk("start_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input int mode);
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 50) begin
      s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom % 2);
      s_data  = d;
      s_last  = last;
      @(negedge clk);
      if (s_valid && s_ready) begin
        ok = 1'b1;
        sb.push_back(model(k, d, cyc + 1));
        k++;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      n++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: word %0h not accepted, expected acceptance", d);
    end
  endtask

  task automatic send_seq(input int from, input int cnt, input int last_at, input int mode, input bit rnd);
    for (int i = from; i < from + cnt; i++)
      send_word(rnd ? $urandom : 32'h100 + i, i == last_at, mode);
  endtask

  task automatic check_end(input string tag, input bit exp_err);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_words"}, 64'(words_loaded), 64'(k));
    chk({tag, "_err"}, 64'(load_err), 64'(exp_err));
    chk({tag, "_done"}, {61'd0, w_done, n_done, h_done},
        {61'd0, 1'(k >= TOT), 1'(k >= HD + ND), 1'(k >= HD)});
    chk({tag, "_idle"}, {62'd0, s_ready, load_busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // reset with a stream word already waiting
    rst = 1'b1; s_valid = 1'b1; s_data = 32'hdead;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {26'd0, load_busy, load_err, s_ready, h_ena, h_wea, n_ena, n_wea, w_ena, w_wea,
                     h_done, n_done, w_done, words_loaded}, 64'd0);
    chk("rst_din", 64'(h_din | n_din | w_din), 64'd0);
    chk("rst_addr", 64'(h_addr | n_addr | w_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_no_ready", 64'(s_ready), 64'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;

    do_start(); send_seq(0, TOT, TOT - 1, 0, 1'b0); check_end("b2b", 1'b0);
    do_start(); send_seq(0, TOT, TOT - 1, 1, 1'b0); check_end("bp", 1'b0);
    do_start(); send_seq(0, 6, 5, 0, 1'b0);         check_end("early", 1'b1);
    do_start(); send_seq(0, TOT, TOT - 1, 2, 1'b1); check_end("reload", 1'b0);
    do_start(); send_seq(0, TOT, -1, 0, 1'b0);      check_end("nolast", 1'b1);

    // start while loading node info is ignored
    do_start(); send_seq(0, 5, -1, 0, 1'b0);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    send_seq(5, 4, TOT - 1, 0, 1'b0); check_end("busy_start", 1'b0);

    // reset mid-load: in-flight strobe completes, nothing after
    do_start(); send_seq(0, 3, -1, 0, 1'b0);
    rst = 1'b1; s_valid = 1'b1; s_data = 32'hbad0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; k = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_ready", 64'(s_ready), 64'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    check_end("rst_mid", 1'b0);

    for (int r = 0; r < 3; r++) begin
      do_start(); send_seq(0, TOT, TOT - 1, 2, 1'b1); check_end("rand", 1'b0);
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
